calc_mem_responder: RTL and testbench
=====================================

CALC_MEM_RESPONDER -- requirements
Module: calc_mem_responder

Interface
REQ-001 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_ni  in  1  asynchronous, active-low reset.
REQ-003 start_i  in  1  single-cycle pulse; advances the mode FSM (LOAD->RUN, DUMP->LOAD).
REQ-004 done_i  in  1  single-cycle pulse from controller when its S_END is reached; RUN->DUMP.
REQ-005 write  in  1  controller write strobe.
REQ-006 w_addr  in  ADDR_W  controller write address.
REQ-007 w_data  in  MEM_WORD_SIZE  controller write data.
REQ-008 read  in  1  controller read strobe.
REQ-009 r_addr  in  ADDR_W  controller read address.
REQ-010 r_data  out  MEM_WORD_SIZE  registered read data to controller.
REQ-011 r_valid  out  1  high the cycle r_data holds a valid response.
REQ-012 host_req  in  1  host access request.
REQ-013 host_we  in  1  host access is a write when 1.
REQ-014 host_addr  in  ADDR_W  host address.
REQ-015 host_wdata  in  MEM_WORD_SIZE  host write data.
REQ-016 host_gnt  out  1  combinational grant; access executes in the cycle host_req && host_gnt.
REQ-017 host_rdata  out  MEM_WORD_SIZE  registered host read data.
REQ-018 host_rvalid  out  1  high one cycle after a granted host read.
REQ-019 mode_o  out  2  current mode_t state.
REQ-020 rd_cnt_o, wr_cnt_o  out  16 each  controller access counters.
REQ-021 access_err_o  out  1  sticky protocol-error flag.

Function
REQ-022 Storage: 2**ADDR_W words of MEM_WORD_SIZE bits; contents not reset.
REQ-023 Mode FSM MODE_LOAD, MODE_RUN, MODE_DUMP; LOAD --start_i--> RUN; RUN --done_i--> DUMP; DUMP --start_i--> LOAD; other pulses ignored.
REQ-024 host_gnt = host_req && mode != MODE_RUN; host denied requests stall without error.
REQ-025 In MODE_RUN, read executes with 1-cycle latency: r_data = mem[r_addr] and r_valid=1 on the following cycle; otherwise r_valid=0 and r_data holds its last value.
REQ-026 In MODE_RUN, write stores w_data at w_addr at the clock edge.
REQ-027 Simultaneous read and write to same address: write-first; r_data returns the new w_data.
REQ-028 Simultaneous read and write to different addresses: both serviced in the same cycle.
REQ-029 Granted host write stores host_wdata; granted host read returns mem[host_addr] on host_rdata with host_rvalid one cycle later; same write-first rule does not apply (host issues one op per cycle).
REQ-030 rd_cnt_o/wr_cnt_o increment per serviced controller read/write, saturate at 16'hFFFF, clear on entry to MODE_RUN from LOAD.
REQ-031 Controller read or write outside MODE_RUN is ignored (no memory change, r_valid=0) and sets access_err_o.
REQ-032 done_i outside MODE_RUN or start_i in MODE_RUN sets access_err_o; access_err_o clears only on reset.
REQ-033 Mode transition and access in the same cycle: access is judged against the pre-transition mode.

Reset
REQ-034 On rst_ni low, immediately: mode=MODE_LOAD, r_data=0, r_valid=0, host_rdata=0, host_rvalid=0, counters=0, access_err_o=0.
REQ-035 Reset mid-operation aborts in-flight reads (no valid pulse after release); memory contents retained.

Structure
REQ-036 mode_t enum, ADDR_W, DATA_W, MEM_WORD_SIZE in calculator_pkg.
REQ-037 Storage in one sub-module calc_mem_array (one write port, two synchronous read ports, write-first on port A).

Verification
REQ-038 Host writes 0x0000_0003_0000_0004 at addr 5 in LOAD, start_i, controller read addr 5 -> r_valid next cycle, r_data equals written word, rd_cnt_o=1.
REQ-039 RUN: write 0xAB at addr 7 and read addr 7 same cycle -> r_data=0xAB next cycle, wr_cnt_o=1.
REQ-040 RUN: host_req=1 -> host_gnt=0 for whole RUN; done_i -> host_gnt=1, host read of addr 7 returns 0xAB with host_rvalid.
REQ-041 LOAD: controller write to addr 2 -> access_err_o=1, subsequent host read of addr 2 shows old value.
REQ-042 Issue 65540 RUN reads -> rd_cnt_o=16'hFFFF.
REQ-043 Assert rst_ni low one cycle after a RUN read -> r_valid never pulses, mode_o=MODE_LOAD, memory retained.

Source files
------------

// File: rtl/calculator_pkg.sv
// Shared types and sizes for the calculator memory responder.
// Mode encoding, word/address widths and a saturating counter helper.
package calculator_pkg;

  localparam int ADDR_W        = 4;
  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 2 * DATA_W;
  localparam int CNT_W         = 16;

  typedef enum logic [1:0] {
    MODE_LOAD = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_DUMP = 2'd2
  } mode_t;

  typedef logic [ADDR_W-1:0]        addr_t;
  typedef logic [MEM_WORD_SIZE-1:0] word_t;
  typedef logic [CNT_W-1:0]         cnt_t;

  function automatic cnt_t sat_inc(
    input cnt_t v,
    input logic en
  );
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/calc_mem_responder_if.sv
// Controller and host access bus of the calculator memory responder.
// master drives requests, slave answers with read data and grant.
interface calc_mem_responder_if;
  import calculator_pkg::*;

  logic  write;
  addr_t w_addr;
  word_t w_data;
  logic  read;
  addr_t r_addr;
  word_t r_data;
  logic  r_valid;

  logic  host_req;
  logic  host_we;
  addr_t host_addr;
  word_t host_wdata;
  logic  host_gnt;
  word_t host_rdata;
  logic  host_rvalid;

  modport master (
    output write, w_addr, w_data,
    output read, r_addr,
    input  r_data, r_valid,
    output host_req, host_we,
    output host_addr, host_wdata,
    input  host_gnt, host_rdata,
    input  host_rvalid
  );

  modport slave (
    input  write, w_addr, w_data,
    input  read, r_addr,
    output r_data, r_valid,
    input  host_req, host_we,
    input  host_addr, host_wdata,
    output host_gnt, host_rdata,
    output host_rvalid
  );

endinterface

// File: rtl/calc_mem_array.sv
// Word storage: one write port, two registered read ports.
// Port A forwards a same-address write; port B reads old data.
module calc_mem_array
  import calculator_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  we_i,
  input  addr_t waddr_i,
  input  word_t wdata_i,
  input  logic  a_re_i,
  input  addr_t a_addr_i,
  output word_t a_rdata_o,
  input  logic  b_re_i,
  input  addr_t b_addr_i,
  output word_t b_rdata_o
);

  word_t mem_q [2**ADDR_W];
  word_t a_rdata_q, a_rdata_d;
  word_t b_rdata_q, b_rdata_d;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_comb begin
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (a_re_i) begin
      a_rdata_d = (we_i && waddr_i == a_addr_i)
                ? wdata_i : mem_q[a_addr_i];
    end
    if (b_re_i) b_rdata_d = mem_q[b_addr_i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/calc_mem_responder.sv
// Memory responder: host loads/dumps, controller reads/writes in RUN.
// Tracks mode, access counters and a sticky protocol-error flag.
module calc_mem_responder
  import calculator_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 done_i,
  calc_mem_responder_if.slave  bus,
  output mode_t                mode_o,
  output logic [CNT_W-1:0]     rd_cnt_o,
  output logic [CNT_W-1:0]     wr_cnt_o,
  output logic                 access_err_o
);

  mode_t mode_q, mode_d;
  cnt_t  rd_cnt_q, rd_cnt_d;
  cnt_t  wr_cnt_q, wr_cnt_d;
  logic  err_q, err_d, err_set;
  logic  r_valid_q, h_valid_q;
  logic  run, ctl_rd, ctl_wr;
  logic  host_rd, host_wr;
  logic  mem_we;
  addr_t mem_waddr;
  word_t mem_wdata;

  // Every access is judged against the mode before this edge.
  assign run     = (mode_q == MODE_RUN);
  assign ctl_rd  = run && bus.read;
  assign ctl_wr  = run && bus.write;
  assign bus.host_gnt = bus.host_req && !run;
  assign host_rd = bus.host_gnt && !bus.host_we;
  assign host_wr = bus.host_gnt && bus.host_we;

  always_comb begin
    mode_d  = mode_q;
    err_set = 1'b0;
    unique case (mode_q)
      MODE_LOAD: begin
        if (start_i) mode_d = MODE_RUN;
        err_set = done_i;
      end
      MODE_RUN: begin
        if (done_i) mode_d = MODE_DUMP;
        err_set = start_i;
      end
      MODE_DUMP: begin
        if (start_i) mode_d = MODE_LOAD;
        err_set = done_i;
      end
      default: mode_d = MODE_LOAD;
    endcase
    if (!run && (bus.read || bus.write)) err_set = 1'b1;
  end

  always_comb begin
    rd_cnt_d = sat_inc(rd_cnt_q, ctl_rd);
    wr_cnt_d = sat_inc(wr_cnt_q, ctl_wr);
    if (mode_q == MODE_LOAD && mode_d == MODE_RUN) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end
    err_d = err_q | err_set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q    <= MODE_LOAD;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_q     <= 1'b0;
      r_valid_q <= 1'b0;
      h_valid_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_q     <= err_d;
      r_valid_q <= ctl_rd;
      h_valid_q <= host_rd;
    end
  end

  // Host and controller never write together: grant excludes RUN.
  assign mem_we    = ctl_wr | host_wr;
  assign mem_waddr = ctl_wr ? bus.w_addr : bus.host_addr;
  assign mem_wdata = ctl_wr ? bus.w_data : bus.host_wdata;

  calc_mem_array u_array (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .we_i     (mem_we),
    .waddr_i  (mem_waddr),
    .wdata_i  (mem_wdata),
    .a_re_i   (ctl_rd),
    .a_addr_i (bus.r_addr),
    .a_rdata_o(bus.r_data),
    .b_re_i   (host_rd),
    .b_addr_i (bus.host_addr),
    .b_rdata_o(bus.host_rdata)
  );

  assign bus.r_valid     = r_valid_q;
  assign bus.host_rvalid = h_valid_q;
  assign mode_o          = mode_q;
  assign rd_cnt_o        = rd_cnt_q;
  assign wr_cnt_o        = wr_cnt_q;
  assign access_err_o    = err_q;

endmodule

// File: tb/tb_calc_mem_responder.sv
// Bench for calc_mem_responder: vector table plus directed sequences.
// Read responses are matched against queued expectations.
module tb_calc_mem_responder;
  import calculator_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic done = 1'b0;
  mode_t mode;
  logic [15:0] rd_cnt, wr_cnt;
  logic err;

  calc_mem_responder_if bus ();

  calc_mem_responder dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .done_i      (done),
    .bus         (bus),
    .mode_o      (mode),
    .rd_cnt_o    (rd_cnt),
    .wr_cnt_o    (wr_cnt),
    .access_err_o(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  word_t rq[$];
  word_t hq[$];
  logic rv_next = 1'b0, rv_exp = 1'b0;
  logic hv_next = 1'b0, hv_exp = 1'b0;

  typedef struct {
    logic  wr;
    addr_t wa;
    word_t wd;
    logic  rd;
    addr_t ra;
    word_t exp;
    logic [15:0] erd;
    logic [15:0] ewr;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.r_valid || rv_exp) begin
      chk("r_valid", {63'd0, bus.r_valid}, {63'd0, rv_exp});
      if (bus.r_valid && rq.size() > 0)
        chk("r_data", bus.r_data, rq.pop_front());
    end
    if (bus.host_rvalid || hv_exp) begin
      chk("host_rvalid", {63'd0, bus.host_rvalid},
          {63'd0, hv_exp});
      if (bus.host_rvalid && hq.size() > 0)
        chk("host_rdata", bus.host_rdata, hq.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    rv_exp = rv_next;
    hv_exp = hv_next;
    #1;
    rv_next = 1'b0;
    hv_next = 1'b0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.host_req = 1'b0;
    bus.host_we = 1'b0;
    start = 1'b0;
    done = 1'b0;
  endtask

  task automatic issue_rd(addr_t a, word_t exp);
    bus.read = 1'b1;
    bus.r_addr = a;
    rq.push_back(exp);
    rv_next = 1'b1;
  endtask

  task automatic hwr(addr_t a, word_t d);
    bus.host_req = 1'b1;
    bus.host_we = 1'b1;
    bus.host_addr = a;
    bus.host_wdata = d;
    step();
  endtask

  task automatic hrd(addr_t a, word_t exp);
    bus.host_req = 1'b1;
    bus.host_we = 1'b0;
    bus.host_addr = a;
    hq.push_back(exp);
    hv_next = 1'b1;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  function automatic word_t pat(int i);
    return 64'hA5A5_0000_0000_0000 | word_t'(i);
  endfunction

  initial begin
    bus.write = 1'b0;
    bus.w_addr = '0;
    bus.w_data = '0;
    bus.read = 1'b0;
    bus.r_addr = '0;
    bus.host_req = 1'b0;
    bus.host_we = 1'b0;
    bus.host_addr = '0;
    bus.host_wdata = '0;

    tbl[0] = '{1'b1, 4'd7, 64'hAB, 1'b1, 4'd7, 64'hAB,
               16'd2, 16'd1};
    tbl[1] = '{1'b1, 4'd3, 64'h33, 1'b1, 4'd5,
               64'h0000_0003_0000_0004, 16'd3, 16'd2};
    tbl[2] = '{1'b0, 4'd0, 64'h0, 1'b1, 4'd3, 64'h33,
               16'd4, 16'd2};
    tbl[3] = '{1'b1, 4'd0, 64'hC0, 1'b0, 4'd0, 64'h0,
               16'd4, 16'd3};
    tbl[4] = '{1'b0, 4'd0, 64'h0, 1'b1, 4'd0, 64'hC0,
               16'd5, 16'd3};
    tbl[5] = '{1'b0, 4'd0, 64'h0, 1'b1, 4'd1,
               64'hA5A5_0000_0000_0001, 16'd6, 16'd3};
    tbl[6] = '{1'b1, 4'd15, '1, 1'b1, 4'd15, '1,
               16'd7, 16'd4};
    tbl[7] = '{1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 64'h0,
               16'd7, 16'd4};

    // reset values while held
    step();
    step();
    chk("rst mode", 64'(mode), 64'(MODE_LOAD));
    chk("rst r_data", bus.r_data, 64'd0);
    chk("rst r_valid", {63'd0, bus.r_valid}, 64'd0);
    chk("rst host_rdata", bus.host_rdata, 64'd0);
    chk("rst host_rvalid", {63'd0, bus.host_rvalid}, 64'd0);
    chk("rst rd_cnt", 64'(rd_cnt), 64'd0);
    chk("rst wr_cnt", 64'(wr_cnt), 64'd0);
    chk("rst err", {63'd0, err}, 64'd0);
    rst_n = 1'b1;

    // LOAD: fill memory from the host
    bus.host_req = 1'b1;
    #1;
    chk("host_gnt LOAD", {63'd0, bus.host_gnt}, 64'd1);
    for (int i = 0; i < 16; i++) hwr(addr_t'(i), pat(i));
    hwr(4'd5, 64'h0000_0003_0000_0004);
    hrd(4'd5, 64'h0000_0003_0000_0004);

    start = 1'b1;
    step();
    chk("mode RUN", 64'(mode), 64'(MODE_RUN));
    chk("cnt clear rd", 64'(rd_cnt), 64'd0);
    issue_rd(4'd5, 64'h0000_0003_0000_0004);
    step();
    chk("rd_cnt first", 64'(rd_cnt), 64'd1);

    // RUN vectors with a host write that must stay denied
    for (int i = 0; i < 8; i++) begin
      bus.host_req = 1'b1;
      bus.host_we = 1'b1;
      bus.host_addr = 4'd4;
      bus.host_wdata = '1;
      #1;
      chk("host_gnt RUN", {63'd0, bus.host_gnt}, 64'd0);
      bus.write = tbl[i].wr;
      bus.w_addr = tbl[i].wa;
      bus.w_data = tbl[i].wd;
      if (tbl[i].rd) issue_rd(tbl[i].ra, tbl[i].exp);
      step();
      chk("vec rd_cnt", 64'(rd_cnt), 64'(tbl[i].erd));
      chk("vec wr_cnt", 64'(wr_cnt), 64'(tbl[i].ewr));
    end

    // done_i with a read in the same cycle: read still serviced
    done = 1'b1;
    issue_rd(4'd7, 64'hAB);
    step();
    chk("mode DUMP", 64'(mode), 64'(MODE_DUMP));
    chk("rd_cnt at done", 64'(rd_cnt), 64'd8);
    chk("err clean", {63'd0, err}, 64'd0);
    bus.host_req = 1'b1;
    #1;
    chk("host_gnt DUMP", {63'd0, bus.host_gnt}, 64'd1);
    hrd(4'd7, 64'hAB);
    hrd(4'd3, 64'h33);
    hrd(4'd4, pat(4));

    start = 1'b1;
    step();
    chk("mode LOAD", 64'(mode), 64'(MODE_LOAD));
    chk("err still clean", {63'd0, err}, 64'd0);

    // controller access in LOAD is ignored and flagged
    bus.write = 1'b1;
    bus.w_addr = 4'd2;
    bus.w_data = 64'h99;
    bus.read = 1'b1;
    bus.r_addr = 4'd2;
    step();
    chk("err load write", {63'd0, err}, 64'd1);
    hrd(4'd2, pat(2));
    step();

    do_reset();
    chk("err after rst", {63'd0, err}, 64'd0);
    done = 1'b1;
    step();
    chk("err done in LOAD", {63'd0, err}, 64'd1);
    chk("mode stays LOAD", 64'(mode), 64'(MODE_LOAD));

    // saturation of the read counter
    do_reset();
    start = 1'b1;
    step();
    for (int i = 0; i < 65540; i++) begin
      issue_rd(4'd0, 64'hC0);
      step();
    end
    step();
    chk("rd_cnt sat", 64'(rd_cnt), 64'hFFFF);
    chk("wr_cnt idle", 64'(wr_cnt), 64'd0);
    chk("err before", {63'd0, err}, 64'd0);
    start = 1'b1;
    step();
    chk("err start RUN", {63'd0, err}, 64'd1);
    chk("mode RUN kept", 64'(mode), 64'(MODE_RUN));

    // reset lands before an in-flight read completes
    bus.read = 1'b1;
    bus.r_addr = 4'd3;
    #3;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("abort mode", 64'(mode), 64'(MODE_LOAD));
    chk("abort r_data", bus.r_data, 64'd0);
    chk("abort err", {63'd0, err}, 64'd0);
    hrd(4'd3, 64'h33);
    hrd(4'd0, 64'hC0);
    step();
    step();

    chk("rq drained", 64'(rq.size()), 64'd0);
    chk("hq drained", 64'(hq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
